// File: rtl/pio_input_shifter.sv
// PIO receive path: samples a wrapped window of GPIO pins into the ISR on IN,
// and moves the ISR into an RX FIFO on PUSH or autopush.
module pio_input_shifter #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [31:0]                     gpio_input,
   input  logic                            in_valid,
   input  logic [4:0]                      in_base,
   input  logic [4:0]                      in_count,
   input  logic                            shift_right,
   input  logic                            autopush_en,
   input  logic [4:0]                      push_thresh,
   input  logic                            push_req,
   input  logic                            push_block,
   output logic                            stall,
   output logic [31:0]                     isr,
   output logic [5:0]                      isr_count,
   output logic [31:0]                     rx_data,
   output logic                            rx_valid,
   input  logic                            rx_ready,
   output logic [$clog2(FIFO_DEPTH):0]     rx_level,
   output logic                            rx_overflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;

   function automatic logic [5:0] sat_count(input logic [6:0] sum);
      return (sum > 7'd32) ? 6'd32 : sum[5:0];
   endfunction

   logic [5:0]    n6;
   logic [5:0]    thresh6;
   logic [63:0]   rot_wide;
   logic [32:0]   mask;
   logic [31:0]   bits;
   logic [31:0]   shifted;
   logic [5:0]    count_sum;
   logic          full;
   logic          pop;
   logic          wr_en;
   logic [31:0]   wr_data;
   logic [31:0]   isr_next;
   logic [5:0]    count_next;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;

   // Zero-encoded fields mean 32; shifts by 32 yield 0, so n = 32 fully replaces the ISR.
   assign n6        = (in_count == 5'd0) ? 6'd32 : {1'b0, in_count};
   assign thresh6   = (push_thresh == 5'd0) ? 6'd32 : {1'b0, push_thresh};
   assign rot_wide  = {gpio_input, gpio_input} >> in_base;
   assign mask      = (33'd1 << n6) - 33'd1;
   assign bits      = rot_wide[31:0] & mask[31:0];
   assign shifted   = shift_right ? ((isr >> n6) | (bits << (6'd32 - n6)))
                                  : ((isr << n6) | bits);
   assign count_sum = sat_count({1'b0, isr_count} + {1'b0, n6});

   assign full     = (rx_level == LW'(FIFO_DEPTH));
   assign rx_valid = (rx_level != '0);
   assign pop      = rx_valid & rx_ready;
   assign rx_data  = rx_valid ? mem[rptr] : 32'd0;

   always_comb begin
      stall       = 1'b0;
      rx_overflow = 1'b0;
      wr_en       = 1'b0;
      wr_data     = isr;
      isr_next    = isr;
      count_next  = isr_count;
      if (in_valid) begin
         if (autopush_en && (count_sum >= thresh6)) begin
            if (full) begin
               stall = 1'b1;
            end else begin
               wr_en      = 1'b1;
               wr_data    = shifted;
               isr_next   = 32'd0;
               count_next = 6'd0;
            end
         end else begin
            isr_next   = shifted;
            count_next = count_sum;
         end
      end else if (push_req) begin
         if (!full) begin
            wr_en      = 1'b1;
            isr_next   = 32'd0;
            count_next = 6'd0;
         end else if (push_block) begin
            stall = 1'b1;
         end else begin
            rx_overflow = 1'b1;
            isr_next    = 32'd0;
            count_next  = 6'd0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         isr       <= 32'd0;
         isr_count <= 6'd0;
         wptr      <= '0;
         rptr      <= '0;
         rx_level  <= '0;
      end else begin
         isr       <= isr_next;
         isr_count <= count_next;
         if (wr_en) wptr <= wptr + 1'b1;
         if (pop)   rptr <= rptr + 1'b1;
         case ({wr_en, pop})
            2'b10:   rx_level <= rx_level + 1'b1;
            2'b01:   rx_level <= rx_level - 1'b1;
            default: rx_level <= rx_level;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed through rx_level.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wptr] <= wr_data;
   end

endmodule

// File: tb/tb_pio_input_shifter.sv
// Directed-vector bench for pio_input_shifter with hand-computed expectations.
module tb_pio_input_shifter;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] gpio_input;
   logic        in_valid;
   logic [4:0]  in_base;
   logic [4:0]  in_count;
   logic        shift_right;
   logic        autopush_en;
   logic [4:0]  push_thresh;
   logic        push_req;
   logic        push_block;
   logic        stall;
   logic [31:0] isr;
   logic [5:0]  isr_count;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [2:0]  rx_level;
   logic        rx_overflow;

   int checks = 0;
   int failures = 0;

   pio_input_shifter #(.FIFO_DEPTH(4)) dut (
      .clk(clk), .rst(rst), .gpio_input(gpio_input), .in_valid(in_valid),
      .in_base(in_base), .in_count(in_count), .shift_right(shift_right),
      .autopush_en(autopush_en), .push_thresh(push_thresh), .push_req(push_req),
      .push_block(push_block), .stall(stall), .isr(isr), .isr_count(isr_count),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_level(rx_level), .rx_overflow(rx_overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
      end
   endtask

   // Advance one clock; inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      in_valid = 0; push_req = 0; push_block = 0; rx_ready = 0;
   endtask

   task automatic do_reset();
      idle();
      gpio_input = 0; in_base = 0; in_count = 0; shift_right = 0;
      autopush_en = 0; push_thresh = 0;
      rst = 0;
      tick();
      rst = 1;
      tick();
   endtask

   task automatic do_in(input logic [31:0] g, input logic [4:0] base, input logic [4:0] cnt);
      gpio_input = g; in_base = base; in_count = cnt; in_valid = 1;
      tick();
      in_valid = 0;
   endtask

   initial begin
      rx_ready = 0;
      do_reset();
      check("rst_isr", isr, 0);
      check("rst_cnt", {26'd0, isr_count}, 0);
      check("rst_valid", {31'd0, rx_valid}, 0);
      check("rst_level", {29'd0, rx_level}, 0);
      check("rst_data", rx_data, 0);
      check("rst_ovf", {31'd0, rx_overflow}, 0);
      check("rst_stall", {31'd0, stall}, 0);

      // Shift left, two 8-bit windows from pin 16
      do_in(32'hA5A5_0000, 5'd16, 5'd8);
      check("left1_isr", isr, 32'h0000_00A5);
      do_in(32'hA5A5_0000, 5'd16, 5'd8);
      check("left2_isr", isr, 32'h0000_A5A5);
      check("left2_cnt", {26'd0, isr_count}, 16);

      // Shift right, new bits at MSB
      do_reset();
      shift_right = 1;
      do_in(32'h0000_000F, 5'd0, 5'd4);
      check("right_isr", isr, 32'hF000_0000);
      check("right_cnt", {26'd0, isr_count}, 4);

      // Full 32-bit IN replaces ISR in both directions
      do_in(32'h1234_5678, 5'd0, 5'd0);
      check("right32_isr", isr, 32'h1234_5678);
      check("right32_cnt", {26'd0, isr_count}, 32);
      shift_right = 0;
      do_in(32'h1234_5678, 5'd4, 5'd0);
      check("left32_isr", isr, 32'h8123_4567);
      check("left32_cnt_sat", {26'd0, isr_count}, 32);

      // Window wrap across pin 31 -> pin 0
      do_reset();
      do_in(32'h4000_0002, 5'd30, 5'd4);
      check("wrap1_isr", isr, 32'h0000_0009);
      do_in(32'h4000_0003, 5'd30, 5'd4);
      check("wrap2_isr", isr, 32'h0000_009D);
      check("wrap2_cnt", {26'd0, isr_count}, 8);

      // Autopush at 8 bits fills the FIFO
      do_reset();
      autopush_en = 1; push_thresh = 5'd8;
      do_in(32'h11, 5'd0, 5'd8);
      check("ap1_valid", {31'd0, rx_valid}, 1);
      check("ap1_data", rx_data, 32'h11);
      check("ap1_cnt", {26'd0, isr_count}, 0);
      do_in(32'h22, 5'd0, 5'd8);
      do_in(32'h33, 5'd0, 5'd8);
      do_in(32'h44, 5'd0, 5'd8);
      check("ap4_level", {29'd0, rx_level}, 4);
      check("ap4_cnt", {26'd0, isr_count}, 0);
      check("ap4_isr", isr, 0);
      gpio_input = 32'h55; in_valid = 1;
      #1;
      check("ap5_stall", {31'd0, stall}, 1);
      tick();
      check("ap5_level_hold", {29'd0, rx_level}, 4);
      check("ap5_cnt_hold", {26'd0, isr_count}, 0);
      check("ap5_stall_hold", {31'd0, stall}, 1);
      check("ap_head", rx_data, 32'h11);
      rx_ready = 1;
      #1;
      check("ap_stall_pop_cycle", {31'd0, stall}, 1);
      tick();
      rx_ready = 0;
      #1;
      check("ap_stall_clear", {31'd0, stall}, 0);
      check("ap_next_head", rx_data, 32'h22);
      check("ap_level3", {29'd0, rx_level}, 3);
      tick();
      in_valid = 0;
      check("ap_retry_level", {29'd0, rx_level}, 4);
      autopush_en = 0;

      // Non-blocking PUSH against full FIFO: drop, clear ISR
      do_in(32'h77, 5'd0, 5'd8);
      check("nb_isr_pre", isr, 32'h77);
      push_req = 1; push_block = 0;
      #1;
      check("nb_ovf", {31'd0, rx_overflow}, 1);
      check("nb_stall", {31'd0, stall}, 0);
      tick();
      push_req = 0;
      #1;
      check("nb_ovf_pulse", {31'd0, rx_overflow}, 0);
      check("nb_isr_clr", isr, 0);
      check("nb_cnt_clr", {26'd0, isr_count}, 0);
      check("nb_level", {29'd0, rx_level}, 4);

      // Blocking PUSH against full FIFO: stall until a pop frees a slot
      do_in(32'h66, 5'd0, 5'd8);
      push_req = 1; push_block = 1;
      #1;
      check("bl_stall", {31'd0, stall}, 1);
      check("bl_no_ovf", {31'd0, rx_overflow}, 0);
      tick();
      check("bl_isr_hold", isr, 32'h66);
      check("bl_level_hold", {29'd0, rx_level}, 4);
      rx_ready = 1;
      tick();
      rx_ready = 0;
      #1;
      check("bl_stall_clear", {31'd0, stall}, 0);
      tick();
      push_req = 0; push_block = 0;
      check("bl_level", {29'd0, rx_level}, 4);
      check("bl_isr_clr", isr, 0);
      rx_ready = 1;
      check("drain0", rx_data, 32'h33);
      tick();
      check("drain1", rx_data, 32'h44);
      tick();
      check("drain2", rx_data, 32'h55);
      tick();
      check("drain3", rx_data, 32'h66);
      tick();
      rx_ready = 0;
      check("drain_empty", {31'd0, rx_valid}, 0);

      // Asynchronous reset mid-operation
      do_reset();
      do_in(32'h1, 5'd0, 5'd8);
      push_req = 1; tick(); push_req = 0;
      do_in(32'h2, 5'd0, 5'd8);
      push_req = 1; tick(); push_req = 0;
      do_in(32'hFFF, 5'd0, 5'd12);
      check("mid_level", {29'd0, rx_level}, 2);
      check("mid_cnt", {26'd0, isr_count}, 12);
      rst = 0;
      #1;
      check("async_isr", isr, 0);
      check("async_cnt", {26'd0, isr_count}, 0);
      check("async_level", {29'd0, rx_level}, 0);
      check("async_valid", {31'd0, rx_valid}, 0);
      check("async_data", rx_data, 0);
      tick();
      rst = 1;
      tick();

      // IN has priority over a simultaneous PUSH
      gpio_input = 32'hAB; in_count = 5'd8; in_base = 0;
      in_valid = 1; push_req = 1;
      tick();
      idle();
      check("prio_isr", isr, 32'hAB);
      check("prio_cnt", {26'd0, isr_count}, 8);
      check("prio_level", {29'd0, rx_level}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got=0x%08h exp=0x%08h", 0, 1);
      $fatal(1, "timeout");
   end

endmodule
